// File: rtl/led_sequencer.sv
// Event queue feeding an RGB LED: each queued colour is shown for a hold
// time and then followed by a dark gap before the next colour is played.
module led_sequencer #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ev_valid,
    input  logic [2:0]                  ev_color,
    output logic                        ev_ready,
    input  logic                        clear,
    output logic [2:0]                  led_color,
    output logic                        led_en,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        bad_color
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    color_n;
    logic          en_n;
    logic          pop;

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_n;
    logic          full, empty, accept, code_ok, push;

    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign ev_ready = rst & ~full & ~clear;
    assign accept   = ev_valid & ev_ready;
    assign code_ok  = (ev_color == 3'd1) | (ev_color == 3'd2) | (ev_color == 3'd3);
    assign push     = accept & code_ok;

    // Counter is loaded only on entry to SHOW/GAP; the state exits when it hits zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        color_n = led_color;
        en_n    = led_en;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SHOW;
                    color_n = mem[rd_ptr];
                    en_n    = 1'b1;
                    cnt_n   = HOLD_LD;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    en_n    = 1'b0;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = SHOW;
                        color_n = mem[rd_ptr];
                        en_n    = 1'b1;
                        cnt_n   = HOLD_LD;
                    end else begin
                        state_n = IDLE;
                        color_n = 3'd0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        level_n = level;
        if (push && !pop) begin
            level_n = level + 1'b1;
        end else if (!push && pop) begin
            level_n = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state     <= IDLE;
            cnt       <= '0;
            led_color <= 3'd0;
            led_en    <= 1'b0;
            busy      <= 1'b0;
            level     <= '0;
            bad_color <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            led_color <= color_n;
            led_en    <= en_n;
            level     <= level_n;
            busy      <= (state_n != IDLE) || (level_n != '0);
            bad_color <= accept & ~code_ok;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ev_color;
        end
    end

endmodule
